pattern_detect_sched: RTL and testbench

PATTERN_DETECT_SCHED -- requirements
Module: pattern_detect_sched

---
 rtl/pattern_detect_sched_if.sv | 27 ++
 rtl/pattern_detect_sched.sv | 147 ++++++++++++++
 tb/tb_pattern_detect_sched.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_detect_sched_if.sv
// Result channel of the pattern-detect scheduler: a valid/ready handshake
// carrying the requester index, the match count and the abort flag.
interface pattern_detect_sched_if #(
    parameter int CNT_W = 4
);
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_id;
    logic [CNT_W-1:0] res_count;
    logic             res_abort;

    modport master (
        output res_valid,
        output res_id,
        output res_count,
        output res_abort,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_id,
        input  res_count,
        input  res_abort,
        output res_ready
    );
endinterface

// File: rtl/pattern_detect_sched.sv
// Round-robin scheduler that time-shares one external "01" Moore detector
// among four serial requesters. Each grant clears the detector, streams
// BURST bits of the owner's serial input through it, absorbs the detector's
// one-cycle output latency, and reports how many matches were seen. The
// owner dropping its request mid-burst ends the burst early with an abort.
module pattern_detect_sched #(
    parameter int NREQ  = 4,
    parameter int BURST = 8,
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] bit_in,
    output logic [NREQ-1:0] gnt,
    output logic            det_a,
    output logic            det_clr,
    input  logic            det_y,
    output logic            busy,
    pattern_detect_sched_if.master res
);

    localparam int ID_W  = 2;
    localparam int BIT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        REPORT
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  cur_id_q, cur_id_d;
    logic [ID_W-1:0]  last_id_q, last_id_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             abort_q, abort_d;

    logic [ID_W-1:0]  pick_id;
    logic [ID_W-1:0]  cand;
    logic             pick_found;

    // Round-robin pick: first active request after the last served requester
    // (the last served one is considered last, so a lone requester still wins).
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = last_id_q + ID_W'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Next-state and output decode; the detector input idles at 1 so a
    // stray 0 can never arm it outside a burst.
    always_comb begin
        state_d       = state_q;
        cur_id_d      = cur_id_q;
        last_id_d     = last_id_q;
        bit_cnt_d     = bit_cnt_q;
        match_cnt_d   = match_cnt_q;
        abort_d       = abort_q;
        gnt           = '0;
        det_a         = 1'b1;
        det_clr       = 1'b0;
        res.res_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    cur_id_d = pick_id;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                gnt         = NREQ'(1) << cur_id_q;
                det_clr     = 1'b1;
                bit_cnt_d   = '0;
                match_cnt_d = '0;
                abort_d     = 1'b0;
                state_d     = RUN;
            end
            RUN: begin
                gnt       = NREQ'(1) << cur_id_q;
                det_a     = bit_in[cur_id_q];
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (det_y) begin
                    match_cnt_d = match_cnt_q + CNT_W'(1);
                end
                if (!req[cur_id_q]) begin
                    abort_d = 1'b1;
                    state_d = REPORT;
                end else if (bit_cnt_q == BIT_W'(BURST - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                gnt = NREQ'(1) << cur_id_q;
                if (det_y) begin
                    match_cnt_d = match_cnt_q + CNT_W'(1);
                end
                state_d = REPORT;
            end
            REPORT: begin
                res.res_valid = 1'b1;
                if (res.res_ready) begin
                    last_id_d = cur_id_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset parks last_id at 3 so the first search starts at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cur_id_q    <= '0;
            last_id_q   <= ID_W'(NREQ - 1);
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            last_id_q   <= last_id_d;
            bit_cnt_q   <= bit_cnt_d;
            match_cnt_q <= match_cnt_d;
            abort_q     <= abort_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign res.res_id    = cur_id_q;
    assign res.res_count = match_cnt_q;
    assign res.res_abort = abort_q;

endmodule

// File: tb/tb_pattern_detect_sched.sv
// Scoreboard bench for pattern_detect_sched: directed scenarios push their
// hand-computed results into a queue, and a monitor pops and compares each
// result when it is accepted on the handshake. The shared "01" detector is
// modelled here.
module tb_pattern_detect_sched;

    localparam int NREQ  = 4;
    localparam int BURST = 8;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [1:0]       id;
        logic [CNT_W-1:0] count;
        logic             abort;
    } res_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] bit_in;
    logic [NREQ-1:0] gnt;
    logic            det_a;
    logic            det_clr;
    logic            det_y;
    logic            busy;

    pattern_detect_sched_if #(.CNT_W(CNT_W)) res_if ();

    pattern_detect_sched #(
        .NREQ (NREQ),
        .BURST(BURST),
        .CNT_W(CNT_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .bit_in (bit_in),
        .gnt    (gnt),
        .det_a  (det_a),
        .det_clr(det_clr),
        .det_y  (det_y),
        .busy   (busy),
        .res    (res_if)
    );

    int checks = 0;
    int passes = 0;

    res_t       exp_q[$];
    res_t       mon_exp;
    logic [7:0] pat [NREQ];
    int         run_idx = 0;
    logic [1:0] det_st;
    int         two_hot = 0;
    logic [3:0] prev_gnt = '0;
    logic [3:0] gnt_log[$];
    logic [3:0] rr_exp [5];
    int         lat;
    bit         ok;

    always #5 clk = ~clk;

    // Shared "01" Moore detector: S0 idle, S1 saw 0, S2 saw 01 (match).
    always @(posedge clk or negedge reset) begin
        if (!reset)              det_st <= 2'd0;
        else if (det_clr)        det_st <= 2'd0;
        else if (!det_a)         det_st <= 2'd1;
        else if (det_st == 2'd1) det_st <= 2'd2;
        else                     det_st <= 2'd0;
    end
    assign det_y = (det_st == 2'd2);

    // Serial sources: index of the current burst bit, restarted by the clear cycle.
    always @(posedge clk) begin
        if (det_clr) run_idx <= 0;
        else         run_idx <= run_idx + 1;
    end

    // Every requester presents its pattern bit for the current burst position.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bit_in[i] = (run_idx < BURST) ? pat[i][run_idx[2:0]] : 1'b0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        $display("[TB] FAIL %s: wait expired, got no event, expected one", name);
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [CNT_W-1:0] count, input logic abort);
        exp_q.push_back({id, count, abort});
    endtask

    task automatic wait_valid(input string name, output bit found);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (res_if.res_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout_fail(name);
    endtask

    task automatic wait_clr(input string name, output bit found);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (det_clr) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout_fail(name);
    endtask

    // Monitor: every accepted result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (reset && res_if.res_valid && res_if.res_ready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_result", {31'd0, res_if.res_valid}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_output("res_id",    32'(res_if.res_id),    32'(mon_exp.id));
                check_output("res_count", 32'(res_if.res_count), 32'(mon_exp.count));
                check_output("res_abort", 32'(res_if.res_abort), 32'(mon_exp.abort));
            end
        end
    end

    // Grant watcher: logs each new grant and counts any multi-hot grant.
    always @(negedge clk) begin
        if ($countones(gnt) > 1) two_hot++;
        if (gnt != 4'b0000 && gnt != prev_gnt) gnt_log.push_back(gnt);
        prev_gnt = gnt;
    end

    // Hard stop in case the scenario sequence itself stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset            = 1'b0;
        req              = '0;
        res_if.res_ready = 1'b0;
        pat[0] = 8'b1101_1010;
        pat[1] = 8'b0100_1001;
        pat[2] = 8'b0101_0101;
        pat[3] = 8'b1111_1110;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset values while reset is held low
        #12;
        check_output("rst_gnt",       32'(gnt),              32'd0);
        check_output("rst_det_clr",   32'(det_clr),          32'd0);
        check_output("rst_det_a",     32'(det_a),            32'd1);
        check_output("rst_res_valid", 32'(res_if.res_valid), 32'd0);
        check_output("rst_res_abort", 32'(res_if.res_abort), 32'd0);
        check_output("rst_res_count", 32'(res_if.res_count), 32'd0);
        check_output("rst_res_id",    32'(res_if.res_id),    32'd0);
        check_output("rst_busy",      32'(busy),             32'd0);
        @(negedge clk);
        reset            = 1'b1;
        res_if.res_ready = 1'b1;

        // Full burst on requester 0: pattern 0,1,0,1,1,0,1,1 -> 3 matches, 11-edge latency
        @(posedge clk); #1;
        req = 4'b0001;
        push_exp(2'd0, 4'd3, 1'b0);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (res_if.res_valid) begin
                lat = n;
                break;
            end
        end
        check_output("latency", 32'(lat), 32'd11);
        req = 4'b0000;
        @(posedge clk); #1;
        check_output("accept_valid_low", 32'(res_if.res_valid), 32'd0);
        check_output("accept_idle",      32'(busy),             32'd0);

        // Round robin from reset with all four requesting
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        gnt_log.delete();
        two_hot = 0;
        push_exp(2'd0, 4'd3, 1'b0);
        push_exp(2'd1, 4'd2, 1'b0);
        push_exp(2'd2, 4'd3, 1'b0);
        push_exp(2'd3, 4'd1, 1'b0);
        push_exp(2'd0, 4'd3, 1'b0);
        @(posedge clk); #1;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_valid("rr_valid", ok);
            if (g == 4) req = 4'b0000;
            @(posedge clk); #1;
        end
        check_output("rr_grant_count", 32'(gnt_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_output("rr_grant", 32'((i < gnt_log.size()) ? gnt_log[i] : 4'b0000), 32'(rr_exp[i]));
        end
        check_output("rr_one_hot", 32'(two_hot), 32'd0);

        // Requester 2 drops req in its third RUN cycle: one match, abort
        pat[2] = 8'b1111_1110;
        req = 4'b0100;
        wait_clr("abort_clr", ok);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 4'b0000;
        push_exp(2'd2, 4'd1, 1'b1);
        @(posedge clk); #1;
        check_output("abort_report_next", 32'(res_if.res_valid), 32'd1);
        check_output("abort_gnt_zero",    32'(gnt),              32'd0);
        @(posedge clk); #1;
        check_output("abort_idle", 32'(busy), 32'd0);

        // Requester 1 result held in REPORT for 5 cycles, accepted on the 6th
        res_if.res_ready = 1'b0;
        req = 4'b0010;
        push_exp(2'd1, 4'd2, 1'b0);
        wait_valid("hold_valid", ok);
        req = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            check_output("hold_valid",  32'(res_if.res_valid), 32'd1);
            check_output("hold_id",     32'(res_if.res_id),    32'd1);
            check_output("hold_count",  32'(res_if.res_count), 32'd2);
            check_output("hold_abort",  32'(res_if.res_abort), 32'd0);
            check_output("hold_gnt",    32'(gnt),              32'd0);
            @(posedge clk); #1;
        end
        res_if.res_ready = 1'b1;
        @(posedge clk); #1;
        check_output("hold_accepted", 32'(res_if.res_valid), 32'd0);
        check_output("hold_idle",     32'(busy),             32'd0);

        // Reset pulse in the middle of requester 1's burst, then a clean restart
        req = 4'b0010;
        wait_clr("mid_clr", ok);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        check_output("midrst_gnt",       32'(gnt),              32'd0);
        check_output("midrst_busy",      32'(busy),             32'd0);
        check_output("midrst_det_a",     32'(det_a),            32'd1);
        check_output("midrst_det_clr",   32'(det_clr),          32'd0);
        check_output("midrst_res_valid", 32'(res_if.res_valid), 32'd0);
        check_output("midrst_res_count", 32'(res_if.res_count), 32'd0);
        check_output("midrst_res_id",    32'(res_if.res_id),    32'd0);
        @(negedge clk) reset = 1'b1;
        push_exp(2'd1, 4'd2, 1'b0);
        wait_clr("restart_clr", ok);
        check_output("restart_clr_gnt", 32'(gnt), 32'b0010);
        @(posedge clk); #1;
        check_output("restart_clr_one_cycle", 32'(det_clr), 32'd0);
        check_output("restart_run_gnt",       32'(gnt),     32'b0010);
        wait_valid("restart_valid", ok);
        req = 4'b0000;
        @(posedge clk); #1;
        check_output("restart_idle", 32'(busy), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
